mem_bank_dp_be: RTL and testbench

//  Parametrised simple-dual-port memory bank: one write port, one read port, one clock.

---
 rtl/mem_bank_pkg.sv | 28 ++
 rtl/mem_bank_dp_array.sv | 41 ++++
 rtl/mem_bank_dp_be.sv | 110 +++++++++++
 tb/tb_mem_bank_dp_be.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared constants and the byte-enable merge helper for the dual-port memory bank.
// No timing of its own; the helper is pure combinational.
// No flow control here.
package mem_bank_pkg;

    localparam int COLL_RBW = 0;
    localparam int COLL_WBR = 1;

    // Widest word the merge helper handles; callers cast in and out.
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] be_merge(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_bank_dp_array.sv
// Bare byte-enabled storage with a registered read port; returns the pre-write word on collision.
// Latency: one clock from read enable to o_dout.
// No flow control; enables are expected pre-qualified by the caller.
module mem_bank_dp_array
    import mem_bank_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int          ADDR_W = 10
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_w_adr,
    input  logic [DATA_W/8-1:0]    i_w_be,
    input  logic [DATA_W-1:0]      i_din,
    input  logic                   i_re,
    input  logic [ADDR_W-1:0]      i_r_adr,
    output logic [DATA_W-1:0]      o_dout
);

    localparam int BE_W = DATA_W / 8;

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_w_be[b]) begin
                    r_mem[i_w_adr][8*b +: 8] <= i_din[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_dout <= r_mem[i_r_adr];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/mem_bank_dp_be.sv
// Simple-dual-port bank with byte enables, RBW/WBR collision policy and read-valid flag.
// Latency: 1 enabled edge, or 2 when MEM_BANK_OUT_REG_EN is defined; i_clk_en=0 freezes all state.
// No backpressure: one read and one write accepted per enabled cycle.
module mem_bank_dp_be
    import mem_bank_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int          ADDR_W = 10,
    parameter int          COLL   = COLL_RBW
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_en,
    input  logic                   i_w_en,
    input  logic [ADDR_W-1:0]      i_w_adr,
    input  logic [DATA_W/8-1:0]    i_w_be,
    input  logic [DATA_W-1:0]      i_din,
    input  logic                   i_r_en,
    input  logic [ADDR_W-1:0]      i_r_adr,
    output logic [DATA_W-1:0]      o_qout,
    output logic                   o_r_valid
);

    localparam int BE_W = DATA_W / 8;

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_arr_re;
    logic              w_coll;
    logic [DATA_W-1:0] w_arr_q;
    logic [DATA_W-1:0] w_merge;
    logic [DATA_W-1:0] w_q1;

    logic              r_rd_vld;
    logic              r_rd_zero;
    logic              r_coll;
    logic [DATA_W-1:0] r_byp_din;
    logic [BE_W-1:0]   r_byp_be;

    assign w_wr_ok  = 32'(i_w_adr) < DEPTH;
    assign w_rd_ok  = 32'(i_r_adr) < DEPTH;
    assign w_wr_acc = i_clk_en & i_w_en & w_wr_ok;
    assign w_rd_acc = i_clk_en & i_r_en;
    assign w_arr_re = w_rd_acc & w_rd_ok;
    // Both accesses in range by construction, so out-of-range pairs never collide.
    assign w_coll   = (COLL == COLL_WBR) && w_wr_acc && w_arr_re && (i_w_adr == i_r_adr);

    mem_bank_dp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc),
        .i_w_adr (i_w_adr),
        .i_w_be  (i_w_be),
        .i_din   (i_din),
        .i_re    (w_arr_re),
        .i_r_adr (i_r_adr),
        .o_dout  (w_arr_q)
    );

    // Side information travels with each accepted read and is held with the array read register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_zero <= 1'b1;
            r_coll    <= 1'b0;
            r_byp_din <= '0;
            r_byp_be  <= '0;
        end else if (i_clk_en) begin
            r_rd_vld <= i_r_en;
            if (i_r_en) begin
                r_rd_zero <= !w_rd_ok;
                r_coll    <= w_coll;
                r_byp_din <= i_din;
                r_byp_be  <= i_w_be;
            end
        end
    end

    assign w_merge = DATA_W'(be_merge(MERGE_MAX_W'(w_arr_q), MERGE_MAX_W'(r_byp_din),
                                      MERGE_MAX_BE'(r_byp_be)));
    assign w_q1    = r_rd_zero ? '0 : (r_coll ? w_merge : w_arr_q);

`ifdef MEM_BANK_OUT_REG_EN
    logic [DATA_W-1:0] r_qout;
    logic              r_vld2;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_qout <= '0;
            r_vld2 <= 1'b0;
        end else if (i_clk_en) begin
            r_qout <= w_q1;
            r_vld2 <= r_rd_vld;
        end
    end

    assign o_qout    = r_qout;
    assign o_r_valid = r_vld2;
`else
    assign o_qout    = w_q1;
    assign o_r_valid = r_rd_vld;
`endif

endmodule

// File: tb/tb_mem_bank_dp_be.sv
// Bench for mem_bank_dp_be: RBW and WBR instances side by side against a word-level memory model.
module tb_mem_bank_dp_be;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int DEP = 1000;
    localparam int BW  = DW / 8;
`ifdef MEM_BANK_OUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          clk_en = 1'b1;
    logic          w_en   = 1'b0;
    logic          r_en   = 1'b0;
    logic [AW-1:0] w_adr  = '0;
    logic [AW-1:0] r_adr  = '0;
    logic [BW-1:0] w_be   = '0;
    logic [DW-1:0] din    = '0;
    logic [DW-1:0] q0, q1;
    logic          v0, v1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: plain word array plus the result visible after every enabled edge.
    logic [DW-1:0] mem_m [0:DEP-1];
    logic          vq  [$];
    logic [DW-1:0] hq0 [$];
    logic [DW-1:0] hq1 [$];
    logic [DW-1:0] held0 = '0;
    logic [DW-1:0] held1 = '0;

    always #5 clk = ~clk;

    mem_bank_dp_be #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .COLL(0)) dut_rbw (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en), .i_w_en(w_en), .i_w_adr(w_adr),
        .i_w_be(w_be), .i_din(din), .i_r_en(r_en), .i_r_adr(r_adr), .o_qout(q0), .o_r_valid(v0));

    mem_bank_dp_be #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .COLL(1)) dut_wbr (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en), .i_w_en(w_en), .i_w_adr(w_adr),
        .i_w_be(w_be), .i_din(din), .i_r_en(r_en), .i_r_adr(r_adr), .o_qout(q1), .o_r_valid(v1));

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 6)      return AW'($urandom_range(0, 31));
        else if (k < 8) return AW'($urandom_range(990, 999));
        else            return AW'($urandom_range(1000, 1023));
    endfunction

    // Advance one clock, updating the model first if the edge will accept anything.
    task automatic tick();
        logic [DW-1:0] old;
        if (rst_n && clk_en) begin
            if (r_en) begin
                if (r_adr >= DEP) begin
                    held0 = '0;
                    held1 = '0;
                end else begin
                    old   = mem_m[r_adr];
                    held0 = old;
                    held1 = (w_en && w_adr == r_adr) ? merge(old, din, w_be) : old;
                end
            end
            if (w_en && w_adr < DEP) mem_m[w_adr] = merge(mem_m[w_adr], din, w_be);
            vq.push_back(r_en);
            hq0.push_back(held0);
            hq1.push_back(held1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        vq.delete();
        hq0.delete();
        hq1.delete();
        held0 = '0;
        held1 = '0;
    endtask

    task automatic get_exp(output logic ev, output logic [DW-1:0] e0, output logic [DW-1:0] e1);
        int n;
        n = vq.size();
        if (n >= L) begin
            ev = vq[n-L];
            e0 = hq0[n-L];
            e1 = hq1[n-L];
        end else begin
            ev = 1'b0;
            e0 = '0;
            e1 = '0;
        end
    endtask

    task automatic set_idle();
        w_en = 1'b0;
        r_en = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic test_reset();
        logic ev;
        logic [DW-1:0] e0, e1;
        rst_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state got v0=%b q0=%h v1=%b q1=%h need all 0", v0, q0, v1, q1);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            get_exp(ev, e0, e1);
            n_cmp++;
            if ({v0, q0, v1, q1} !== {ev, e0, ev, e1} || v0 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got v0=%b q0=%h v1=%b q1=%h need v=0 q=0", i, v0, q0, v1, q1);
            end
        end
    endtask

    task automatic init_mem();
        w_en = 1'b1;
        w_be = '1;
        for (int a = 0; a < 32; a++) begin
            w_adr = AW'(a);
            din = $urandom;
            tick();
        end
        for (int a = 990; a < DEP; a++) begin
            w_adr = AW'(a);
            din = $urandom;
            tick();
        end
        set_idle();
    endtask

    task automatic test_write_read();
        logic ev;
        logic [DW-1:0] e0, e1;
        w_en = 1'b1; w_adr = 5; w_be = 4'hF; din = 32'hDEADBEEF;
        tick();
        w_en = 1'b0; r_en = 1'b1; r_adr = 5;
        tick();
        r_en = 1'b0;
        repeat (L-1) tick();
        get_exp(ev, e0, e1);
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF} || {ev, e0} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL wr_rd got v0=%b q0=%h v1=%b q1=%h need v=1 q=deadbeef", v0, q0, v1, q1);
        end
        tick();
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL wr_rd_hold got v0=%b q0=%h v1=%b q1=%h need v=0 q=deadbeef", v0, q0, v1, q1);
        end
    endtask

    task automatic test_collision();
        w_en = 1'b1; w_adr = 7; w_be = 4'hF; din = 32'h11223344;
        tick();
        w_adr = 7; w_be = 4'b0101; din = 32'hAABBCCDD; r_en = 1'b1; r_adr = 7;
        tick();
        set_idle();
        repeat (L-1) tick();
        n_cmp++;
        if ({v0, q0} !== {1'b1, 32'h11223344}) begin
            n_err++;
            $display("FAIL coll_rbw got v=%b q=%h need v=1 q=11223344", v0, q0);
        end
        n_cmp++;
        if ({v1, q1} !== {1'b1, 32'h11BB33DD}) begin
            n_err++;
            $display("FAIL coll_wbr got v=%b q=%h need v=1 q=11bb33dd", v1, q1);
        end
        r_en = 1'b1; r_adr = 7;
        tick();
        r_en = 1'b0;
        repeat (L-1) tick();
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b1, 32'h11BB33DD, 1'b1, 32'h11BB33DD}) begin
            n_err++;
            $display("FAIL coll_after got q0=%h q1=%h need 11bb33dd", q0, q1);
        end
    endtask

    task automatic test_back_to_back();
        logic ev;
        logic [DW-1:0] e0, e1;
        int pulses;
        pulses = 0;
        for (int s = 0; s < 9; s++) begin
            clk_en = !(s >= 2 && s <= 4);
            r_en   = (s <= 5);
            r_adr  = (s == 0) ? 10'd0 : (s == 1) ? 10'd1 : 10'd2;
            tick();
            get_exp(ev, e0, e1);
            if (clk_en && v0 === 1'b1) pulses++;
            n_cmp++;
            if ({v0, q0, v1, q1} !== {ev, e0, ev, e1}) begin
                n_err++;
                $display("FAIL b2b step=%0d got v0=%b q0=%h v1=%b q1=%h need v=%b q=%h", s, v0, q0, v1, q1, ev, e0);
            end
        end
        set_idle();
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL b2b_pulses got %0d need 3", pulses);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] keep;
        keep = mem_m[999];
        w_en = 1'b1; w_adr = 10'd1000; w_be = 4'hF; din = 32'hFFFFFFFF;
        tick();
        w_en = 1'b0; r_en = 1'b1; r_adr = 10'd1000;
        tick();
        r_en = 1'b0;
        repeat (L-1) tick();
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL oor_read got v0=%b q0=%h v1=%b q1=%h need v=1 q=0", v0, q0, v1, q1);
        end
        w_en = 1'b1; w_adr = 10'd1023; w_be = 4'hF; din = 32'h12345678; r_en = 1'b1; r_adr = 10'd1023;
        tick();
        set_idle();
        repeat (L-1) tick();
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL oor_coll got v0=%b q0=%h v1=%b q1=%h need v=1 q=0", v0, q0, v1, q1);
        end
        r_en = 1'b1; r_adr = 10'd999;
        tick();
        r_en = 1'b0;
        repeat (L-1) tick();
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b1, keep, 1'b1, keep}) begin
            n_err++;
            $display("FAIL oor_999 got q0=%h q1=%h need %h", q0, q1, keep);
        end
    endtask

    task automatic test_reset_mid_read();
        logic ev;
        logic [DW-1:0] e0, e1;
        r_en = 1'b1; r_adr = 7;
        tick();
        r_en = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL rst_mid got v0=%b q0=%h v1=%b q1=%h need all 0", v0, q0, v1, q1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < L + 1; i++) begin
            tick();
            get_exp(ev, e0, e1);
            n_cmp++;
            if ({v0, q0, v1, q1} !== {ev, e0, ev, e1} || v0 !== 1'b0) begin
                n_err++;
                $display("FAIL rst_release cyc=%0d got v0=%b q0=%h v1=%b q1=%h need v=0 q=0", i, v0, q0, v1, q1);
            end
        end
        r_en = 1'b1; r_adr = 7;
        tick();
        r_en = 1'b0;
        repeat (L-1) tick();
        n_cmp++;
        if ({v0, q0, v1, q1} !== {1'b1, 32'h11BB33DD, 1'b1, 32'h11BB33DD}) begin
            n_err++;
            $display("FAIL rst_survive got q0=%h q1=%h need 11bb33dd", q0, q1);
        end
    endtask

    task automatic test_random();
        logic ev;
        logic [DW-1:0] e0, e1;
        for (int i = 0; i < 400; i++) begin
            clk_en = ($urandom_range(0, 9) < 8);
            w_en   = $urandom_range(0, 1);
            r_en   = $urandom_range(0, 1);
            w_adr  = pick_addr();
            r_adr  = ($urandom_range(0, 3) == 0) ? w_adr : pick_addr();
            w_be   = BW'($urandom);
            din    = $urandom;
            tick();
            get_exp(ev, e0, e1);
            n_cmp++;
            if ({v0, q0} !== {ev, e0}) begin
                n_err++;
                $display("FAIL rand_rbw cyc=%0d got v=%b q=%h need v=%b q=%h", i, v0, q0, ev, e0);
            end
            n_cmp++;
            if ({v1, q1} !== {ev, e1}) begin
                n_err++;
                $display("FAIL rand_wbr cyc=%0d got v=%b q=%h need v=%b q=%h", i, v1, q1, ev, e1);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        init_mem();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
